instr_prefetch_buffer: RTL

Instruction prefetch queue between the SPI program-memory controller and the CPU fetch/decode path. It issues sequential single-word fetch requests, buffers up to DEPTH returned instructions tagged with their address, and presents the head entry to the decoder. A branch redirect flushes the queue. An in-flight SPI transaction always completes; its returned data is discarded.

---
 rtl/prefetch_pkg.sv | 15 +
 rtl/prefetch_fifo.sv | 61 ++++++
 rtl/instr_prefetch_buffer.sv | 118 +++++++++++
 3 files changed

// File: rtl/prefetch_pkg.sv
// Shared types and default sizes for the instruction prefetch buffer.
// The FSM state encoding is fixed so that a checker can decode the top's state_q.
package prefetch_pkg;

   localparam int DEPTH_DEF  = 4;
   localparam int ADDR_W_DEF = 16;
   localparam int DATA_W_DEF = 16;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      DRAIN = 2'd2
   } state_t;

endpackage

// File: rtl/prefetch_fifo.sv
// Circular FIFO of {addr, data} pairs with a zeroed head when empty.
// Flush takes priority over push and pop.
module prefetch_fifo #(
   parameter int DEPTH  = 4,
   parameter int ADDR_W = 16,
   parameter int DATA_W = 16
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    push,
   input  logic                    pop,
   input  logic                    flush,
   input  logic [ADDR_W-1:0]       push_addr,
   input  logic [DATA_W-1:0]       push_data,
   output logic [$clog2(DEPTH):0]  count,
   output logic [ADDR_W-1:0]       head_addr,
   output logic [DATA_W-1:0]       head_data
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

   logic [ADDR_W-1:0] addr_mem [DEPTH];
   logic [DATA_W-1:0] data_mem [DEPTH];
   logic [PTR_W-1:0]  wr_ptr;
   logic [PTR_W-1:0]  rd_ptr;
   logic              do_push;
   logic              do_pop;

   assign do_push = push && !flush && (count != FULL);
   assign do_pop  = pop && !flush && (count != '0);

   always_ff @(posedge clk) begin
      if (rst || flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // Storage needs no reset: an entry is only read after it has been written.
   always_ff @(posedge clk) begin
      if (do_push) begin
         addr_mem[wr_ptr] <= push_addr;
         data_mem[wr_ptr] <= push_data;
      end
   end

   assign head_addr = (count != '0) ? addr_mem[rd_ptr] : '0;
   assign head_data = (count != '0) ? data_mem[rd_ptr] : '0;

endmodule

// File: rtl/instr_prefetch_buffer.sv
// Sequential instruction prefetcher: one outstanding SPI fetch at a time, results
// queued with their address; a redirect flushes the queue and drains any live fetch.
module instr_prefetch_buffer
   import prefetch_pkg::*;
#(
   parameter int                DEPTH      = DEPTH_DEF,
   parameter int                ADDR_W     = ADDR_W_DEF,
   parameter int                DATA_W     = DATA_W_DEF,
   parameter logic [ADDR_W-1:0] RESET_ADDR = '0
) (
   input  logic                   clk,
   input  logic                   rst,
   output logic                   mem_req,
   output logic [ADDR_W-1:0]      mem_addr,
   input  logic                   mem_ack,
   input  logic [DATA_W-1:0]      mem_data,
   output logic                   instr_valid,
   output logic [DATA_W-1:0]      instr,
   output logic [ADDR_W-1:0]      instr_pc,
   input  logic                   instr_take,
   input  logic                   redirect,
   input  logic [ADDR_W-1:0]      redirect_addr,
   output logic [$clog2(DEPTH):0] fill_level
);

   localparam int CNT_W = $clog2(DEPTH) + 1;
   localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

   // Handshakes: mem_req/mem_addr are held from issue until the cycle mem_ack is
   // sampled high (mem_ack is a one-cycle completion pulse); the decoder pops the
   // head on any cycle where instr_valid and instr_take are both high.

   state_t            state_q;
   state_t            state_d;
   logic [ADDR_W-1:0] fetch_addr;
   logic [ADDR_W-1:0] fetch_addr_d;
   logic              mem_req_d;
   logic [ADDR_W-1:0] mem_addr_d;
   logic              push;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         fetch_addr <= RESET_ADDR;
         mem_req    <= 1'b0;
         mem_addr   <= '0;
      end else begin
         state_q    <= state_d;
         fetch_addr <= fetch_addr_d;
         mem_req    <= mem_req_d;
         mem_addr   <= mem_addr_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      fetch_addr_d = fetch_addr;
      mem_req_d    = mem_req;
      mem_addr_d   = mem_addr;
      push         = 1'b0;
      case (state_q)
         IDLE: begin
            if (redirect) begin
               fetch_addr_d = redirect_addr;
            end else if (fill_level < FULL) begin
               state_d    = FETCH;
               mem_req_d  = 1'b1;
               mem_addr_d = fetch_addr;
            end
         end
         FETCH: begin
            if (redirect) begin
               fetch_addr_d = redirect_addr;
               if (mem_ack) begin
                  mem_req_d = 1'b0;
                  state_d   = IDLE;
               end else begin
                  state_d = DRAIN;
               end
            end else if (mem_ack) begin
               push         = 1'b1;
               fetch_addr_d = mem_addr + 1'b1;
               mem_req_d    = 1'b0;
               state_d      = IDLE;
            end
         end
         DRAIN: begin
            // The stale transaction must still finish; its data is simply not pushed.
            if (redirect) fetch_addr_d = redirect_addr;
            if (mem_ack) begin
               mem_req_d = 1'b0;
               state_d   = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   prefetch_fifo #(
      .DEPTH  (DEPTH),
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (push),
      .pop       (instr_take),
      .flush     (redirect),
      .push_addr (mem_addr),
      .push_data (mem_data),
      .count     (fill_level),
      .head_addr (instr_pc),
      .head_data (instr)
   );

   assign instr_valid = (fill_level != '0);

endmodule
